// File: rtl/mesh_router_xy.sv
// rtl/mesh_router_xy.sv - five-port XY mesh router with per-input FIFOs and round-robin outputs
//
// Purpose: buffers flits per input port, routes each FIFO head by dimension-ordered
// XY routing and shares each output among requesters with a round-robin pointer.
// Ports (slot p of a 5-slot bus is bits [p*DATA_WIDTH +: DATA_WIDTH];
//        index 0 local, 1 north, 2 south, 3 east, 4 west):
//   clk, reset     single clock, synchronous active-high reset
//   in_data        flit offered per input port
//   in_write       write strobe per input port
//   in_full        input FIFO full (registered count == FIFO_DEPTH)
//   out_data       registered flit per output port
//   out_write_req  one-cycle strobe, out_data slot valid
//   out_full       downstream full per output port
module mesh_router_xy #(
    parameter int DATA_WIDTH = 8,
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5*DATA_WIDTH-1:0] in_data,
    input  logic [4:0]              in_write,
    output logic [4:0]              in_full,
    output logic [5*DATA_WIDTH-1:0] out_data,
    output logic [4:0]              out_write_req,
    input  logic [4:0]              out_full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [X_W-1:0] MY_X_L = X_W'(MY_X);
    localparam logic [Y_W-1:0] MY_Y_L = Y_W'(MY_Y);

    logic [DATA_WIDTH-1:0] mem_q  [5][FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q [5];
    logic [PTR_W-1:0]      rptr_q [5];
    logic [CNT_W-1:0]      cnt_q  [5];
    logic [CNT_W-1:0]      cnt_d  [5];
    logic [2:0]            rr_q   [5];
    logic [2:0]            rr_d   [5];

    logic [5*DATA_WIDTH-1:0] out_data_q;
    logic [4:0]              out_write_req_q;

    logic [DATA_WIDTH-1:0] head     [5];
    logic [X_W-1:0]        dest_x   [5];
    logic [Y_W-1:0]        dest_y   [5];
    logic [2:0]            route    [5];
    logic [4:0]            nonempty;
    logic [4:0]            push;
    logic [4:0]            pop;
    logic [4:0]            gnt_vld;
    logic [2:0]            gnt_src  [5];

    // Head decode and XY route: resolve X first, then Y, else deliver locally.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            head[p]     = mem_q[p][rptr_q[p]];
            dest_x[p]   = head[p][DATA_WIDTH-1 -: X_W];
            dest_y[p]   = head[p][DATA_WIDTH-1-X_W -: Y_W];
            nonempty[p] = (cnt_q[p] != '0);
            in_full[p]  = (cnt_q[p] == CNT_W'(FIFO_DEPTH));
            push[p]     = in_write[p] && !in_full[p];
            if (dest_x[p] > MY_X_L)      route[p] = 3'd3;
            else if (dest_x[p] < MY_X_L) route[p] = 3'd4;
            else if (dest_y[p] > MY_Y_L) route[p] = 3'd1;
            else if (dest_y[p] < MY_Y_L) route[p] = 3'd2;
            else                         route[p] = 3'd0;
        end
    end

    // Round-robin grant per output: first requester at or after rr_q[o].
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < 5; o++) begin
            gnt_vld[o] = 1'b0;
            gnt_src[o] = 3'd0;
            rr_d[o]    = rr_q[o];
            if (!out_full[o]) begin
                for (int k = 0; k < 5; k++) begin
                    idx = (int'(rr_q[o]) + k) % 5;
                    if (!gnt_vld[o] && nonempty[idx] && route[idx] == 3'(o)) begin
                        gnt_vld[o] = 1'b1;
                        gnt_src[o] = 3'(idx);
                    end
                end
            end
            if (gnt_vld[o]) begin
                rr_d[o] = (gnt_src[o] == 3'd4) ? 3'd0 : gnt_src[o] + 3'd1;
            end
        end
        // An input heads to a single output, so it is popped by at most one grant.
        for (int p = 0; p < 5; p++) begin
            pop[p] = 1'b0;
            for (int o = 0; o < 5; o++) begin
                if (gnt_vld[o] && gnt_src[o] == 3'(p)) pop[p] = 1'b1;
            end
            cnt_d[p] = cnt_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
        end
    end

    // Storage needs no reset: emptiness is tracked by the counts alone.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 5; p++) begin
            if (push[p]) mem_q[p][wptr_q[p]] <= in_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 5; p++) begin
                wptr_q[p] <= '0;
                rptr_q[p] <= '0;
                cnt_q[p]  <= '0;
                rr_q[p]   <= '0;
            end
            out_write_req_q <= '0;
            out_data_q      <= '0;
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (push[p]) wptr_q[p] <= wptr_q[p] + 1'b1;
                if (pop[p])  rptr_q[p] <= rptr_q[p] + 1'b1;
                cnt_q[p] <= cnt_d[p];
                rr_q[p]  <= rr_d[p];
            end
            for (int o = 0; o < 5; o++) begin
                out_write_req_q[o] <= gnt_vld[o];
                if (gnt_vld[o]) begin
                    out_data_q[o*DATA_WIDTH +: DATA_WIDTH] <= head[gnt_src[o]];
                end
            end
        end
    end

    assign out_data      = out_data_q;
    assign out_write_req = out_write_req_q;
endmodule

// File: tb/tb_mesh_router_xy.sv
// tb/tb_mesh_router_xy.sv - self-checking bench for mesh_router_xy at node (1,1)
module tb_mesh_router_xy;
    localparam int DW    = 8;
    localparam int MX    = 1;
    localparam int MY    = 1;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5*DW-1:0] in_data = '0;
    logic [4:0]    in_write = '0;
    logic [4:0]    in_full;
    logic [5*DW-1:0] out_data;
    logic [4:0]    out_write_req;
    logic [4:0]    out_full = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mesh_router_xy #(
        .DATA_WIDTH(DW), .X_W(2), .Y_W(2), .MY_X(MX), .MY_Y(MY), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_write(in_write),
        .in_full(in_full), .out_data(out_data), .out_write_req(out_write_req),
        .out_full(out_full)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, routing by plain coordinate comparison.
    logic [7:0]    mq [5][$];
    int            mrr [5] = '{0, 0, 0, 0, 0};
    logic [4:0]    m_req = '0;
    logic [5*DW-1:0] m_data = '0;

    function automatic int route_of(input logic [7:0] f);
        int x = int'(f[7:6]);
        int y = int'(f[5:4]);
        if (x > MX) return 3;
        if (x < MX) return 4;
        if (y > MY) return 1;
        if (y < MY) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        bit full_b [5];
        bit g [5];
        int src [5];
        int s;
        if (reset) begin
            for (int p = 0; p < 5; p++) begin
                mq[p].delete();
                mrr[p] = 0;
            end
            m_req  = '0;
            m_data = '0;
        end else begin
            for (int p = 0; p < 5; p++) full_b[p] = (mq[p].size() == DEPTH);
            for (int o = 0; o < 5; o++) begin
                g[o] = 0;
                src[o] = 0;
                if (!out_full[o]) begin
                    for (int k = 0; k < 5; k++) begin
                        s = (mrr[o] + k) % 5;
                        if (!g[o] && mq[s].size() > 0 && route_of(mq[s][0]) == o) begin
                            g[o] = 1;
                            src[o] = s;
                        end
                    end
                end
                m_req[o] = g[o];
                if (g[o]) begin
                    m_data[o*DW +: DW] = mq[src[o]][0];
                    mrr[o] = (src[o] + 1) % 5;
                end
            end
            for (int o = 0; o < 5; o++) if (g[o]) void'(mq[src[o]].pop_front());
            for (int p = 0; p < 5; p++)
                if (in_write[p] && !full_b[p]) mq[p].push_back(in_data[p*DW +: DW]);
        end
    end

    always @(negedge clk) begin : compare
        logic [4:0] mf;
        for (int p = 0; p < 5; p++) mf[p] = (mq[p].size() == DEPTH);
        check("model_out_write_req", 40'(out_write_req), 40'(m_req));
        check("model_out_data", out_data, m_data);
        check("model_in_full", 40'(in_full), 40'(mf));
    end

    logic [7:0] pat [3] = '{8'h51, 8'h52, 8'h54};

    initial begin
        // Reset held two cycles with all strobes high.
        in_write = 5'h1F;
        in_data  = 40'h55_55_55_55_55;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        in_write = '0;
        @(negedge clk);
        check("reset_out_write_req", 40'(out_write_req), 40'h0);
        check("reset_out_data", out_data, 40'h0);
        check("reset_in_full", 40'(in_full), 40'h0);

        // Local loop: dest (1,1) on local input.
        in_data[7:0] = 8'h55;
        in_write = 5'b00001;
        @(negedge clk);
        in_write = '0;
        check("local_not_yet", 40'(out_write_req), 40'h0);
        @(negedge clk);
        check("local_req", 40'(out_write_req), 40'h01);
        check("local_data", 40'(out_data[7:0]), 40'h55);
        @(negedge clk);
        check("local_req_clear", 40'(out_write_req), 40'h0);

        // XY routing: each input targets a distinct output.
        in_data  = {8'h12, 8'h91, 8'h44, 8'h73, 8'h55};
        in_write = 5'h1F;
        @(negedge clk);
        in_write = '0;
        @(negedge clk);
        check("xy_req", 40'(out_write_req), 40'h1F);
        check("xy_data", out_data, 40'h12_91_44_73_55);

        // Contention on local output from north, south, west.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        in_data  = {8'h54, 8'h00, 8'h52, 8'h51, 8'h00};
        in_write = 5'b10110;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("contend_req", 40'(out_write_req[0]), 40'h1);
            check("contend_order", 40'(out_data[7:0]), 40'(pat[i % 3]));
        end
        in_write = '0;
        repeat (14) @(negedge clk);

        // Backpressure on east with a full west FIFO.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        out_full = 5'b01000;
        for (int i = 0; i < 6; i++) begin
            in_data[39:32] = 8'h91 + 8'(i);
            in_write = 5'b10000;
            @(negedge clk);
            if (i == 2) check("bp_not_full", 40'(in_full[4]), 40'h0);
            if (i == 3) check("bp_full", 40'(in_full[4]), 40'h1);
        end
        in_write = '0;
        check("bp_no_out", 40'(out_write_req), 40'h0);
        @(negedge clk);
        out_full = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_req", 40'(out_write_req), 40'h08);
            check("bp_data", 40'(out_data[31:24]), 40'(8'h91 + 8'(i)));
        end
        @(negedge clk);
        check("bp_done", 40'(out_write_req), 40'h0);
        check("bp_in_full_clear", 40'(in_full), 40'h0);

        // Reset mid-operation with three buffered flits.
        out_full = 5'b01000;
        for (int i = 0; i < 3; i++) begin
            in_data[39:32] = 8'h9A + 8'(i);
            in_write = 5'b10000;
            @(negedge clk);
        end
        in_write = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        out_full = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_req", 40'(out_write_req), 40'h0);
            check("midrst_in_full", 40'(in_full), 40'h0);
        end
        in_data[7:0] = 8'h5D;
        in_write = 5'b00001;
        @(negedge clk);
        in_write = '0;
        @(negedge clk);
        check("midrst_after_req", 40'(out_write_req), 40'h01);
        check("midrst_after_data", 40'(out_data[7:0]), 40'h5D);

        // Randomized traffic with backpressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            in_write = 5'($urandom);
            for (int p = 0; p < 5; p++) in_data[p*DW +: DW] = 8'($urandom);
            for (int o = 0; o < 5; o++) out_full[o] = ($urandom_range(0, 9) < 3);
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        in_write = '0;
        out_full = '0;
        repeat (25) @(negedge clk);
        check("drain_idle", 40'(out_write_req), 40'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
